// File: rtl/cavlc_blk_encoding_if.sv
`default_nettype none
// ============================================================================
// Module      : cavlc_blk_encoding_if
// Description : Handshake bundle between the CAVLC block scanner and its
//               coefficient source / bitstream writer. master = source and
//               writer side, slave = scanner side.
// Revision    : 1.0 - initial release
// ============================================================================
interface cavlc_blk_encoding_if #(
    parameter int COEFF_W = 16
);
    // block start and coefficient load
    logic                      blk_start;
    logic [4:0]                maxNumCoeff;
    logic                      coeff_valid;
    logic signed [COEFF_W-1:0] coeff_in;
    logic                      coeff_ready;
    // coeff_token header
    logic                      hdr_valid;
    logic                      hdr_ready;
    logic [4:0]                TotalCoeff;
    logic [1:0]                TrailingOnes;
    logic [3:0]                TotalZeros;
    // level / run_before pairs
    logic                      lvl_valid;
    logic                      lvl_ready;
    logic signed [COEFF_W-1:0] level_out;
    logic [3:0]                run_before;
    logic [3:0]                zerosLeft;
    logic [3:0]                i_TotalCoeff;
    logic                      end_of_NonZeroCoeff_enc;
    logic                      blk_done;

    modport master (
        output blk_start, maxNumCoeff, coeff_valid, coeff_in, hdr_ready, lvl_ready,
        input  coeff_ready, hdr_valid, TotalCoeff, TrailingOnes, TotalZeros,
               lvl_valid, level_out, run_before, zerosLeft, i_TotalCoeff,
               end_of_NonZeroCoeff_enc, blk_done
    );

    modport slave (
        input  blk_start, maxNumCoeff, coeff_valid, coeff_in, hdr_ready, lvl_ready,
        output coeff_ready, hdr_valid, TotalCoeff, TrailingOnes, TotalZeros,
               lvl_valid, level_out, run_before, zerosLeft, i_TotalCoeff,
               end_of_NonZeroCoeff_enc, blk_done
    );
endinterface
`default_nettype wire

// File: rtl/cavlc_blk_encoding.sv
`default_nettype none
// ============================================================================
// Module      : cavlc_blk_encoding
// Description : CAVLC residual block scanner (encoder side). Loads one zigzag
//               ordered block, produces TotalCoeff / TrailingOnes / TotalZeros,
//               then emits level / run_before pairs in reverse scan order.
//               Optional macro CAVLC_LEVEL_CLIP_EN saturates incoming
//               coefficients to +/-LEVEL_LIMIT.
// Revision    : 1.0 - initial release
// ============================================================================
module cavlc_blk_encoding #(
    parameter int COEFF_W     = 16,
    parameter int LEVEL_LIMIT = 2063
) (
    input  wire logic          clk,
    input  wire logic          reset,
    cavlc_blk_encoding_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_HEADER = 3'd2,
        S_SCAN   = 3'd3,
        S_EMIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic signed [COEFF_W-1:0] r_buf [0:15];
    logic [4:0]                r_maxNum;
    logic [4:0]                r_idx;
    logic [4:0]                r_totalCoeff;
    logic [4:0]                r_t1cnt;
    logic [3:0]                r_lastNz;
    // bit 4 flags that the scan pointer has stepped below position 0
    logic [4:0]                r_ptr;
    logic                      r_scanFirst;
    logic signed [COEFF_W-1:0] r_level;
    logic [3:0]                r_run;
    logic [3:0]                r_zerosLeft;
    logic [3:0]                r_iTc;

    logic signed [COEFF_W-1:0] w_coeff;
    logic                      w_beat;
    logic                      w_lastBeat;
    logic                      w_nonzero;
    logic                      w_isOne;
    logic                      w_hdrFire;
    logic                      w_lvlFire;
    logic signed [COEFF_W-1:0] w_scanCoeff;
    logic                      w_scanStop;
    logic [3:0]                w_totalZeros;

`ifdef CAVLC_LEVEL_CLIP_EN
    localparam logic signed [COEFF_W-1:0] c_limPos = COEFF_W'(LEVEL_LIMIT);
    localparam logic signed [COEFF_W-1:0] c_limNeg = -c_limPos;

    // saturate before storage so the trailing-ones test sees the stored value
    always_comb begin
        w_coeff = bus.coeff_in;
        if (bus.coeff_in > c_limPos) begin
            w_coeff = c_limPos;
        end else if (bus.coeff_in < c_limNeg) begin
            w_coeff = c_limNeg;
        end
    end
`else
    assign w_coeff = bus.coeff_in;
`endif

    assign w_beat       = (r_state == S_LOAD) && bus.coeff_valid;
    assign w_lastBeat   = w_beat && (r_idx == (r_maxNum - 5'd1));
    assign w_nonzero    = (w_coeff != '0);
    assign w_isOne      = (w_coeff == COEFF_W'(1)) || (w_coeff == {COEFF_W{1'b1}});
    assign w_hdrFire    = (r_state == S_HEADER) && bus.hdr_ready;
    assign w_lvlFire    = (r_state == S_EMIT) && bus.lvl_ready;
    assign w_scanCoeff  = r_buf[r_ptr[3:0]];
    // first SCAN cycle only latches the level; later cycles walk the zeros
    assign w_scanStop   = !r_scanFirst && (r_ptr[4] || (w_scanCoeff != '0));
    // 4-bit wrap keeps the TotalCoeff==16 case (15+1-16) correct at 0
    assign w_totalZeros = (r_totalCoeff == 5'd0) ? 4'd0
                        : (r_lastNz + 4'd1 - r_totalCoeff[3:0]);

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // next-state decode
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:   if (bus.blk_start) w_nextState = S_LOAD;
            S_LOAD:   if (w_lastBeat)    w_nextState = S_HEADER;
            S_HEADER: if (w_hdrFire)     w_nextState = (r_totalCoeff == 5'd0) ? S_DONE : S_SCAN;
            S_SCAN:   if (w_scanStop)    w_nextState = S_EMIT;
            S_EMIT:   if (w_lvlFire)     w_nextState = (r_iTc == 4'd0) ? S_DONE : S_SCAN;
            S_DONE:                      w_nextState = S_IDLE;
            default:                     w_nextState = S_IDLE;
        endcase
    end

    // coefficient buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_buf[r_idx[3:0]] <= w_coeff;
        end
    end

    // load statistics, header fields and scan/emit datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_maxNum     <= '0;
            r_idx        <= '0;
            r_totalCoeff <= '0;
            r_t1cnt      <= '0;
            r_lastNz     <= '0;
            r_ptr        <= '0;
            r_scanFirst  <= 1'b0;
            r_level      <= '0;
            r_run        <= '0;
            r_zerosLeft  <= '0;
            r_iTc        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.blk_start) begin
                        r_maxNum     <= bus.maxNumCoeff;
                        r_idx        <= '0;
                        r_totalCoeff <= '0;
                        r_t1cnt      <= '0;
                        r_lastNz     <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_beat) begin
                        r_idx <= r_idx + 5'd1;
                        if (w_nonzero) begin
                            r_totalCoeff <= r_totalCoeff + 5'd1;
                            r_lastNz     <= r_idx[3:0];
                            r_t1cnt      <= w_isOne ? (r_t1cnt + 5'd1) : 5'd0;
                        end
                    end
                end
                S_HEADER: begin
                    if (w_hdrFire) begin
                        r_ptr       <= {1'b0, r_lastNz};
                        r_iTc       <= r_totalCoeff[3:0] - 4'd1;
                        r_zerosLeft <= w_totalZeros;
                        r_scanFirst <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (r_scanFirst) begin
                        r_level     <= w_scanCoeff;
                        r_run       <= '0;
                        r_ptr       <= r_ptr - 5'd1;
                        r_scanFirst <= 1'b0;
                    end else if (!w_scanStop) begin
                        r_run <= r_run + 4'd1;
                        r_ptr <= r_ptr - 5'd1;
                    end
                end
                S_EMIT: begin
                    // r_ptr already sits on the next nonzero, so SCAN resumes there
                    if (w_lvlFire) begin
                        r_zerosLeft <= r_zerosLeft - r_run;
                        r_scanFirst <= 1'b1;
                        if (r_iTc != 4'd0) begin
                            r_iTc <= r_iTc - 4'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.coeff_ready             = (r_state == S_LOAD);
    assign bus.hdr_valid               = (r_state == S_HEADER);
    assign bus.TotalCoeff              = r_totalCoeff;
    assign bus.TrailingOnes            = (r_t1cnt > 5'd3) ? 2'd3 : r_t1cnt[1:0];
    assign bus.TotalZeros              = w_totalZeros;
    assign bus.lvl_valid               = (r_state == S_EMIT);
    assign bus.level_out               = r_level;
    assign bus.run_before              = r_run;
    assign bus.zerosLeft               = r_zerosLeft;
    assign bus.i_TotalCoeff            = r_iTc;
    assign bus.end_of_NonZeroCoeff_enc = (r_state == S_EMIT) && (r_iTc == 4'd0);
    assign bus.blk_done                = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: doc/cavlc_blk_encoding.md
Name: cavlc_blk_encoding

Overview:
- Encoder-side CAVLC residual block scanner, the counterpart of the decoder's end-of-block detection.
- Accepts one 4x4 (or chroma DC) coefficient block in zigzag order and computes the coeff_token header fields: TotalCoeff, TrailingOnes and TotalZeros.
- Then emits level/run_before pairs in reverse scan order to the downstream CAVLC bitstream writer.
- Flags the last pair with end_of_NonZeroCoeff_enc, when i_TotalCoeff reaches 0.

Parameters:
- COEFF_W, 16, signed coefficient width.
- LEVEL_LIMIT, 2063, magnitude clip bound; used only when CAVLC_LEVEL_CLIP_EN is defined.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- blk_start  input  1  one-cycle pulse; latches maxNumCoeff and begins a block; accepted only in IDLE.
- maxNumCoeff  input  5  coefficients per block: 16, 15 or 4.
- coeff_valid  input  1  coeff_in is valid.
- coeff_in  input  COEFF_W  signed coefficient, zigzag order, index 0 first.
- coeff_ready  output  1  high in LOAD only.
- hdr_valid  output  1  header fields valid.
- hdr_ready  input  1  writer consumed the header.
- TotalCoeff  output  5  nonzero count, 0..16.
- TrailingOnes  output  2  0..3.
- TotalZeros  output  4  zeros below the last nonzero.
- lvl_valid  output  1  level/run pair valid.
- lvl_ready  input  1  writer consumed the pair.
- level_out  output  COEFF_W  signed level.
- run_before  output  4  zeros between this level and the next lower nonzero.
- zerosLeft  output  4  zeros remaining below this level, before subtracting run_before.
- i_TotalCoeff  output  4  index of the current pair; counts down to 0.
- end_of_NonZeroCoeff_enc  output  1  high together with lvl_valid on the pair where i_TotalCoeff==0.
- blk_done  output  1  one-cycle pulse when the block completes.

Behaviour:
- Reset: state=IDLE. All outputs are 0; buffer contents are don't-care.
- Reset mid-block aborts immediately with no blk_done.
- States: IDLE, LOAD, HEADER, SCAN, EMIT, DONE.
- IDLE -> LOAD on blk_start. Clears idx, TotalCoeff, t1cnt and last_nz.
- LOAD:
  - Each coeff_valid&coeff_ready beat stores coeff_in at buf[idx] and increments idx.
  - If the coefficient is nonzero: TotalCoeff+1 and last_nz=idx.
  - If |c|==1, t1cnt+1; otherwise t1cnt=0. Zero coefficients leave t1cnt unchanged.
  - After the beat with idx==maxNumCoeff-1, go to HEADER next cycle.
- HEADER:
  - TrailingOnes=min(t1cnt,3).
  - TotalZeros = last_nz+1-TotalCoeff, or 0 if TotalCoeff==0.
  - hdr_valid is held with stable fields until hdr_ready.
  - On handshake: if TotalCoeff==0, go to DONE (no pairs, no end flag). Otherwise go to SCAN with ptr=last_nz, i_TotalCoeff=TotalCoeff-1, zerosLeft=TotalZeros.
- SCAN:
  - Latch level=buf[ptr] and clear run; ptr decrements by one per cycle.
  - Each zero visited increments run.
  - On reaching a nonzero, or ptr underflow past 0 for the lowest level, go to EMIT.
  - Latency is one cycle per buffer position visited.
- EMIT:
  - lvl_valid is held until lvl_ready.
  - On handshake: zerosLeft -= run_before.
  - If i_TotalCoeff==0, go to DONE. Otherwise decrement i_TotalCoeff and return to SCAN.
  - No further SCAN visit is needed when the next nonzero has already been reached.
  - For the lowest level, run_before equals the remaining zerosLeft. The writer omits coding it.
- DONE: blk_done pulses for one cycle, then IDLE.
- blk_start outside IDLE is ignored.
- coeff_valid outside LOAD is ignored.
- Coefficient value -2^(COEFF_W-1) is passed through unclipped when the clip feature is absent.

Optional Feature:
- Macro: CAVLC_LEVEL_CLIP_EN.
- Defined: coeff_in is saturated to [-LEVEL_LIMIT, +LEVEL_LIMIT] before storage and before the |c|==1 test.
- Undefined: values are stored verbatim and LEVEL_LIMIT is unused.

Test Plan:
- Block 0,3,-1,0,0,-1,1,0,1,0x7 with maxNumCoeff=16 -> header TotalCoeff=5, TrailingOnes=3, TotalZeros=4. Pairs, each given as (level,run,zerosLeft,i): (1,1,4,4), (1,0,3,3), (-1,2,3,2), (-1,0,1,1), (3,1,1,0). end_of_NonZeroCoeff_enc is high only on the last pair.
- All-zero block, maxNumCoeff=15 -> TotalCoeff=0, TotalZeros=0. No lvl_valid; blk_done is asserted one cycle after the hdr handshake.
- Chroma DC block -2,1,1,1 with maxNumCoeff=4 -> TotalCoeff=4, TrailingOnes=3, TotalZeros=0. All run_before=0; the last pair has level -2 with i_TotalCoeff=0.
- Backpressure: hdr_ready and lvl_ready held low for 5 cycles each -> outputs remain stable, with no lost or duplicated pair.
- Reset asserted mid-EMIT -> all outputs are 0 asynchronously. A new block after reset encodes correctly.
- With CAVLC_LEVEL_CLIP_EN: coeff_in=+3000 -> level_out=+2063. Without the macro -> level_out=+3000.
